// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM encoding and index-width helper.
package reg_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request bit at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDXW = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [IDXW-1:0]  winner,
  output logic             found
);

  logic [N_REQ-1:0] hit;
  logic [IDXW-1:0]  idx [N_REQ];

  // hit[k] is the request of the requester k positions after ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign idx[gi] = IDXW'((int'(ptr) + gi) % N_REQ);
      assign hit[gi] = req[idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest offset is the last assignment.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        winner = idx[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// One WIDTH-bit register shared by N_REQ requesters through a round-robin grant/commit/ack FSM.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDXW = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IDXW-1:0]        owner,
  output logic                   busy
);

  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic [IDXW-1:0]  owner_q;
  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  win_q;
  logic [IDXW-1:0]  ptr_d;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;
  logic [N_REQ-1:0] win_onehot;
  logic [WIDTH-1:0] lane [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  assign pick_onehot = N_REQ'(1) << pick_idx;
  assign win_onehot  = N_REQ'(1) << win_q;
  assign ptr_d       = (win_q == IDXW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
    end else begin
      // Clear comes first so a same-edge commit write overrides it.
      if (clr) begin
        q_q       <= '0;
        q_valid_q <= 1'b0;
        owner_q   <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (pick_found) begin
            gnt_q   <= pick_onehot;
            win_q   <= pick_idx;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (req[win_q]) begin
            q_q       <= lane[win_q];
            owner_q   <= win_q;
            q_valid_q <= 1'b1;
            ack_q     <= win_onehot;
            state_q   <= ST_COMMIT;
          end else begin
            // Withdrawn request: drop the grant and leave ptr where it was.
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench: driver predicts each commit from the round-robin rule, monitor checks every ack.
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [1:0]     owner;
  logic           busy;

  reg_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;

  // Reference state, updated at transaction level.
  int         m_ptr;
  logic [7:0] m_q;
  logic       m_valid;
  int         m_owner;
  logic [3:0] req_v;
  logic [31:0] wdata_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_q = 8'h00; m_valid = 1'b0; m_owner = 0;
  endtask

  // Entered with the DUT idle so the next edge is an arbitration edge.
  task automatic round(input logic [3:0] add, input logic [31:0] data,
                       input bit withdraw, input bit clr_wr, input bit clr_after);
    int w;
    chk("idle_q", q, m_q);
    chk("idle_q_valid", q_valid, m_valid);
    chk("idle_owner", owner, m_owner);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < N; i++)
      if (add[i] && !req_v[i]) wdata_v[i*8 +: 8] = data[i*8 +: 8];
    req_v = req_v | add;
    req = req_v;
    wdata = wdata_v;
    w = pick(req_v, m_ptr);
    if (w < 0) begin
      @(posedge clk); #1;
      chk("no_req_gnt", gnt, 0);
      return;
    end
    @(posedge clk); #1;
    chk("gnt", gnt, 32'(1) << w);
    chk("busy_grant", busy, 1);
    if (withdraw) begin
      req_v[w] = 1'b0;
      req = req_v;
      @(posedge clk); #1;
      chk("withdraw_gnt", gnt, 0);
      chk("withdraw_ack", ack, 0);
      chk("withdraw_busy", busy, 0);
      $display("txn withdraw idx=%0d", w);
      return;
    end
    exp_q.push_back('{idx: w, data: wdata_v[w*8 +: 8]});
    clr = clr_wr;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("drv_ack", ack, 32'(1) << w);
    m_q = wdata_v[w*8 +: 8]; m_valid = 1'b1; m_owner = w; m_ptr = (w + 1) % N;
    req_v[w] = 1'b0;
    req = req_v;
    clr = clr_after;
    @(posedge clk); #1;
    clr = 1'b0;
    if (clr_after) begin
      m_q = 8'h00; m_valid = 1'b0; m_owner = 0;
    end
    chk("commit_ack", ack, 0);
    chk("commit_gnt", gnt, 0);
    chk("commit_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_onehot", gnt & (gnt - 4'd1), 0);
      chk("ack_in_gnt", ack & ~gnt, 0);
      if (ack != 0) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_ack: got ack=%b, required no ack", ack);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_ack", ack, 32'(1) << mon_e.idx);
          chk("sb_q", q, mon_e.data);
          chk("sb_owner", owner, mon_e.idx);
          chk("sb_q_valid", q_valid, 1);
          $display("txn write idx=%0d data=%02h q=%02h", mon_e.idx, mon_e.data, q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = '0; wdata = '0; clr = 1'b0;
    req_v = '0; wdata_v = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single write from requester 2.
    round(4'b0100, 32'h00A5_0000, 0, 0, 0);

    // Reset asserted while requester 1 is in GRANT.
    req_v = 4'b0010;
    req = req_v;
    @(posedge clk); #1;
    chk("pre_rst_gnt", gnt, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_q", q, 0);
    chk("midrst_q_valid", q_valid, 0);
    chk("midrst_busy", busy, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    round(4'b0000, 32'h0, 0, 0, 0);

    // Requester 3 writes 3C with clr on the same edge, then clr alone.
    round(4'b1000, 32'h3C00_0000, 0, 1, 1);

    // All four requesting: rotation 0,1,2,3 then back to 0.
    round(4'b1111, 32'h1312_1110, 0, 0, 0);
    repeat (3) round(4'b0000, 32'h0, 0, 0, 0);
    round(4'b1111, 32'h2322_2120, 0, 0, 0);
    while (req_v != 0) round(4'b0000, 32'h0, 0, 0, 0);

    // ptr=3 after requester 2; 0101 must yield 0 then 2.
    round(4'b0100, 32'h0055_0000, 0, 0, 0);
    round(4'b0101, 32'h0066_0077, 0, 0, 0);
    round(4'b0000, 32'h0, 0, 0, 0);

    // Withdraw leaves ptr at 3, so 0011 picks 0 before 1.
    round(4'b0001, 32'h0000_00EE, 1, 0, 0);
    round(4'b0011, 32'h0000_9988, 0, 0, 0);
    round(4'b0000, 32'h0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [3:0] add;
      add = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) add = 4'b0000;
      round(add, $urandom, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    while (req_v != 0) round(4'b0000, 32'h0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop storage register between N_REQ requesters.
- A round-robin arbiter selects one requester; a 3-state FSM sequences grant, then commit, then acknowledge.
- Used wherever several producers must update a single state register without collisions.
- Output q is the register contents. owner identifies the last writer.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width of the shared register.
- IDXW, $clog2(N_REQ), width of requester index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester write request; level, held until ack.
- wdata  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of q/q_valid/owner.
- gnt  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-hot single-cycle write-complete pulse.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  q has been written since reset/clear.
- owner  output  IDXW  index of last committed writer.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: clocked with clk. Only the clock is named in the codebase's convention; reset is asynchronous and active-low on rst.
- While rst=0, all of the following are 0, asynchronously: gnt, ack, q, q_valid, owner, busy, and round-robin pointer ptr. State is IDLE.
- FSM states: IDLE, GRANT, COMMIT.
- IDLE: if req!=0, pick winner w. The winner is the first set bit of req at or above ptr, wrapping modulo N_REQ. Register gnt=onehot(w) and go to GRANT. If req=0, stay in IDLE.
- GRANT: sample req[w].
  - If req[w]=1: load q<=wdata[w], owner<=w, q_valid<=1. Pulse ack[w]=1 on the following cycle, gnt stays asserted. Go to COMMIT.
  - If req[w]=0 (requester withdrew): no write, no ack, gnt<=0, ptr unchanged. Go to IDLE.
- COMMIT: ack and gnt return to 0. ptr<=(w+1) mod N_REQ. Go to IDLE.
- Latency: req rises before edge k. gnt is high after edge k. q updates and ack is high after edge k+1. Back in IDLE after edge k+2.
- Minimum request-to-request spacing is 3 cycles. Requesters must drop req in the cycle ack is seen, otherwise they are re-arbitrated.
- busy=1 in GRANT and COMMIT.
- Requests from non-winners arriving during GRANT/COMMIT are held off. They are only considered in IDLE.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 commits.
- clr=1: q<=0, q_valid<=0, owner<=0 on the next edge, in any state. FSM, gnt and ptr are unaffected.
  - If clr coincides with the GRANT->COMMIT write edge, the write wins: q=wdata[w], q_valid=1.
- Reset mid-transaction (rst low in GRANT or COMMIT): immediate return to IDLE, no ack generated, q cleared.
- Single requester (only one bit of req set): always granted regardless of ptr.
- ptr wraps from N_REQ-1 to 0.
- gnt and ack are never multi-hot. ack is never asserted without gnt on the same bit.

Decomposition:
- Shared package/include holds:
  - State encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_COMMIT=2'd2.
  - The clog2 helper used to derive IDXW.
- One sub-module: rr_pick.
  - Inputs: req, ptr. Outputs: winner index and found flag.
  - Purely combinational.
  - Instantiated once in reg_share_arbiter. The FSM and register bank stay in the top.

Test Plan:
- Reset: drive rst=0 mid-GRANT with req=4'b0010 → gnt=0, ack=0, q=0, q_valid=0, busy=0 immediately. After release, first grant goes to requester 1.
- Single write: req=4'b0100, wdata lane2=8'hA5 → gnt=4'b0100 at k+1. At k+2: ack=4'b0100 for one cycle, q=8'hA5, owner=2, q_valid=1.
- Round-robin: req=4'b1111 held, lane i data = 8'h10+i, each requester drops req after its ack → ack order 0,1,2,3. q sequence 10,11,12,13. Next grant after re-request goes to 0.
- Wrap and skip: ptr=3, req=4'b0101 → winner 0, then winner 2. Requester 1 is never granted.
- Withdraw: req=4'b0001 asserted, then dropped during GRANT → no ack, q unchanged, ptr unchanged. Back in IDLE after one cycle.
- Clear collision: clr=1 on the same edge as the write of 8'h3C from requester 3 → q=8'h3C, q_valid=1. clr alone next cycle → q=0, q_valid=0, owner=0.
